// File: rtl/stream_mux_n_to_1_pkg.sv
// Shared types and constants for the FFT stream selector.
package fft_stream_pkg;

  // Frame-lock state of the selector.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Channel-selection modes.
  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Width of the accepted-beat counter.
  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/stream_mux_n_to_1_if.sv
// Bundle of the stream selector's data/handshake signals.
// master: the surrounding datapath (sources + sink); slave: the selector.
interface stream_mux_n_to_1_if
  import fft_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) ();

  logic [NUM_CH*DATA_WIDTH-1:0] D;
  logic [NUM_CH-1:0]            D_VALID;
  logic [NUM_CH-1:0]            D_LAST;
  logic [NUM_CH-1:0]            D_READY;
  logic [SEL_WIDTH-1:0]         SEL;
  logic                         MODE;
  logic [DATA_WIDTH-1:0]        Y;
  logic                         Y_VALID;
  logic                         Y_LAST;
  logic [SEL_WIDTH-1:0]         Y_CH;
  logic                         Y_READY;
  logic                         BUSY;
  logic [BEAT_CNT_W-1:0]        BEAT_CNT;

  modport master (
    output D, D_VALID, D_LAST, SEL, MODE, Y_READY,
    input  D_READY, Y, Y_VALID, Y_LAST, Y_CH, BUSY, BEAT_CNT
  );

  modport slave (
    input  D, D_VALID, D_LAST, SEL, MODE, Y_READY,
    output D_READY, Y, Y_VALID, Y_LAST, Y_CH, BUSY, BEAT_CNT
  );

endinterface

// File: rtl/stream_mux_n_to_1_rr_arbiter.sv
// Combinational round-robin channel picker: the first requesting channel
// after the pointer (with wrap) wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              grant_ok
);

  // Scan ptr+1, ptr+2, ... ptr+NUM_CH (mod NUM_CH); the last slot is ptr itself.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_ok && req[i] && (((int'(ptr) + off) % NUM_CH) == i)) begin
          grant_ok = 1'b1;
          grant    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 valid/ready frame selector with a registered output stage.
// A grant is taken in IDLE (static SEL or round-robin) and held until the
// beat carrying D_LAST has been accepted.
// Optional feature: define STREAM_MUX_BEAT_CNT_EN to build the 16-bit
// accepted-output-beat counter on BEAT_CNT (tied to zero otherwise).
module stream_mux_n_to_1
  import fft_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input logic                CLK,
  input logic                RST,
  stream_mux_n_to_1_if.slave bus
);

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   y_last_q, y_last_d;
  logic [SEL_WIDTH-1:0]   y_ch_q, y_ch_d;

  logic [SEL_WIDTH-1:0]   rr_grant;
  logic                   rr_ok;
  logic [SEL_WIDTH-1:0]   grant;
  logic                   grant_ok;
  logic                   load_en;
  logic                   accept;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [NUM_CH-1:0]      d_ready;

  // Bit of vec addressed by idx; indices past the last channel read as 0,
  // which is what makes an out-of-range SEL produce no grant.
  function automatic logic bit_at(input logic [NUM_CH-1:0] vec,
                                  input logic [SEL_WIDTH-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == SEL_WIDTH'(i)) r = vec[i];
    end
    return r;
  endfunction

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (SEL_WIDTH)
  ) u_rr_arbiter (
    .req      (bus.D_VALID),
    .ptr      (ptr_q),
    .grant    (rr_grant),
    .grant_ok (rr_ok)
  );

  // Pick the channel being served: frozen while locked, else by mode.
  always_comb begin
    grant    = grant_q;
    grant_ok = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant    = grant_q;
      grant_ok = bit_at(bus.D_VALID, grant_q);
    end else if (bus.MODE == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_ok;
    end else begin
      grant    = bus.SEL;
      grant_ok = bit_at(bus.D_VALID, bus.SEL);
    end
  end

  assign load_en  = !y_valid_q || bus.Y_READY;
  assign accept   = grant_ok && load_en;
  assign sel_last = bit_at(bus.D_LAST, grant);

  // Route the granted channel's data and one-hot ready.
  always_comb begin
    sel_data = '0;
    d_ready  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        sel_data   = bus.D[i*DATA_WIDTH +: DATA_WIDTH];
        d_ready[i] = accept;
      end
    end
  end

  // Frame lock and round-robin pointer: pointer moves only on frame close.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sel_last) begin
            ptr_d = grant;
          end else begin
            state_d = ST_LOCKED;
            grant_d = grant;
          end
        end
      end
      ST_LOCKED: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          ptr_d   = grant;
        end
      end
    endcase
  end

  // Output register: load on accept, drop valid once the sink has taken it.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    y_ch_d    = y_ch_q;
    if (accept) begin
      y_d       = sel_data;
      y_valid_d = 1'b1;
      y_last_d  = sel_last;
      y_ch_d    = grant;
    end else if (bus.Y_READY) begin
      y_valid_d = 1'b0;
    end
  end

  // State, pointer and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= SEL_WIDTH'(NUM_CH - 1);
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      y_ch_q    <= y_ch_d;
    end
  end

`ifdef STREAM_MUX_BEAT_CNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Count output handshakes; wraps naturally at 2**BEAT_CNT_W.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (y_valid_q && bus.Y_READY) beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
  end

  // Beat counter register.
  always_ff @(posedge CLK) begin
    if (RST) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign bus.BEAT_CNT = beat_cnt_q;
`else
  assign bus.BEAT_CNT = '0;
`endif

  assign bus.D_READY = d_ready;
  assign bus.Y       = y_q;
  assign bus.Y_VALID = y_valid_q;
  assign bus.Y_LAST  = y_last_q;
  assign bus.Y_CH    = y_ch_q;
  assign bus.BUSY    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Directed bench for stream_mux_n_to_1 (NUM_CH=4, SEL_WIDTH=3, DATA_WIDTH=32).
// Channel i always presents {tag, i, 16'hBEEF} so each output beat names
// both its source channel and the cycle it was offered.
module tb_stream_mux_n_to_1;

`ifdef STREAM_MUX_BEAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stream_mux_n_to_1_if #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(3)) bus ();

  stream_mux_n_to_1 #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(3)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  dv;
    logic [3:0]  dl;
    logic [7:0]  tag;
    logic        yr;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_y;
    logic        exp_last;
    logic [2:0]  exp_ch;
    logic        exp_busy;
  } vec_t;

  vec_t vt[$];

  function automatic logic [15:0] exp_cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic mode, input logic [2:0] sel,
                       input logic [3:0] dv, input logic [3:0] dl,
                       input logic [7:0] tag, input logic yr);
    rst         = r;
    bus.MODE    = mode;
    bus.SEL     = sel;
    bus.D_VALID = dv;
    bus.D_LAST  = dl;
    bus.Y_READY = yr;
    for (int i = 0; i < 4; i++) bus.D[i*32 +: 32] = {tag, 8'(i), 16'hBEEF};
  endtask

  task automatic add(input logic r, input logic mode, input logic [2:0] sel,
                     input logic [3:0] dv, input logic [3:0] dl, input logic [7:0] tag,
                     input logic [3:0] erdy, input logic evld, input logic [31:0] ey,
                     input logic elast, input logic [2:0] ech, input logic ebusy);
    vec_t v;
    v.rst = r; v.mode = mode; v.sel = sel; v.dv = dv; v.dl = dl; v.tag = tag; v.yr = 1'b1;
    v.exp_rdy = erdy; v.exp_vld = evld; v.exp_y = ey; v.exp_last = elast;
    v.exp_ch = ech; v.exp_busy = ebusy;
    vt.push_back(v);
  endtask

  // Drive one vector, check ready before the edge and the registers after.
  task automatic apply(input vec_t v, input int idx);
    string tg;
    tg = $sformatf("vec%0d", idx);
    drive(v.rst, v.mode, v.sel, v.dv, v.dl, v.tag, v.yr);
    #1;
    chk({tg, " D_READY"}, 32'(bus.D_READY), 32'(v.exp_rdy));
    @(posedge clk); #1;
    chk({tg, " Y_VALID"}, 32'(bus.Y_VALID), 32'(v.exp_vld));
    chk({tg, " BUSY"}, 32'(bus.BUSY), 32'(v.exp_busy));
    if (v.exp_vld || v.rst) begin
      chk({tg, " Y"}, bus.Y, v.exp_y);
      chk({tg, " Y_LAST"}, 32'(bus.Y_LAST), 32'(v.exp_last));
      chk({tg, " Y_CH"}, 32'(bus.Y_CH), 32'(v.exp_ch));
    end
    if (v.rst) chk({tg, " BEAT_CNT"}, 32'(bus.BEAT_CNT), 32'(exp_cnt(0)));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 8'h00, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 8'h00, 1'b1);

    // Test 1: static SEL=2, four-beat frame.
    add(0,0,2,4'b0100,4'b0000,8'h10, 4'b0100,1,32'h1002BEEF,0,2,1);
    add(0,0,2,4'b0100,4'b0000,8'h11, 4'b0100,1,32'h1102BEEF,0,2,1);
    add(0,0,2,4'b0100,4'b0000,8'h12, 4'b0100,1,32'h1202BEEF,0,2,1);
    add(0,0,2,4'b0100,4'b0100,8'h13, 4'b0100,1,32'h1302BEEF,1,2,0);
    add(0,0,2,4'b0000,4'b0000,8'h14, 4'b0000,0,32'h0,0,0,0);
    // Reset so round-robin starts from channel 0.
    add(1,1,0,4'b0000,4'b0000,8'h00, 4'b0000,0,32'h0,0,0,0);
    // Test 2: round-robin, all valid, two-beat frames.
    add(0,1,0,4'b1111,4'b0000,8'h20, 4'b0001,1,32'h2000BEEF,0,0,1);
    add(0,1,0,4'b1111,4'b0001,8'h21, 4'b0001,1,32'h2100BEEF,1,0,0);
    add(0,1,0,4'b1111,4'b0000,8'h22, 4'b0010,1,32'h2201BEEF,0,1,1);
    add(0,1,0,4'b1111,4'b0010,8'h23, 4'b0010,1,32'h2301BEEF,1,1,0);
    add(0,1,0,4'b1111,4'b0000,8'h24, 4'b0100,1,32'h2402BEEF,0,2,1);
    add(0,1,0,4'b1111,4'b0100,8'h25, 4'b0100,1,32'h2502BEEF,1,2,0);
    add(0,1,0,4'b1111,4'b0000,8'h26, 4'b1000,1,32'h2603BEEF,0,3,1);
    add(0,1,0,4'b1111,4'b1000,8'h27, 4'b1000,1,32'h2703BEEF,1,3,0);
    add(0,1,0,4'b1111,4'b0000,8'h28, 4'b0001,1,32'h2800BEEF,0,0,1);
    add(0,1,0,4'b1111,4'b0001,8'h29, 4'b0001,1,32'h2900BEEF,1,0,0);
    // Locked channel drops valid mid-frame: nobody else is served.
    add(0,1,0,4'b1111,4'b0000,8'h2A, 4'b0010,1,32'h2A01BEEF,0,1,1);
    add(0,1,0,4'b1101,4'b0000,8'h2B, 4'b0000,0,32'h0,0,0,1);
    add(0,1,0,4'b1111,4'b0010,8'h2C, 4'b0010,1,32'h2C01BEEF,1,1,0);
    // Test 4: SEL/MODE changes while locked on ch1 are ignored.
    add(0,0,1,4'b1111,4'b0000,8'h40, 4'b0010,1,32'h4001BEEF,0,1,1);
    add(0,0,3,4'b1111,4'b0000,8'h41, 4'b0010,1,32'h4101BEEF,0,1,1);
    add(0,1,3,4'b1111,4'b0010,8'h42, 4'b0010,1,32'h4201BEEF,1,1,0);
    add(0,0,3,4'b1111,4'b1000,8'h43, 4'b1000,1,32'h4303BEEF,1,3,0);
    // Out-of-range SEL and an idle selected channel: no grant.
    add(0,0,7,4'b1111,4'b0000,8'h44, 4'b0000,0,32'h0,0,0,0);
    add(0,0,7,4'b1111,4'b0000,8'h45, 4'b0000,0,32'h0,0,0,0);
    add(0,0,2,4'b1011,4'b0000,8'h46, 4'b0000,0,32'h0,0,0,0);
    // Test 5: reset mid-frame, then round-robin restarts at ch0.
    add(0,1,0,4'b1111,4'b0001,8'h50, 4'b0001,1,32'h5000BEEF,1,0,0);
    add(0,1,0,4'b1111,4'b0000,8'h51, 4'b0010,1,32'h5101BEEF,0,1,1);
    add(1,1,0,4'b1111,4'b0000,8'h52, 4'b0010,0,32'h0,0,0,0);
    add(0,1,0,4'b1111,4'b0000,8'h53, 4'b0001,1,32'h5300BEEF,0,0,1);
    add(0,1,0,4'b1111,4'b0001,8'h54, 4'b0001,1,32'h5400BEEF,1,0,0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst Y_VALID", 32'(bus.Y_VALID), 32'd0);
    chk("rst BUSY", 32'(bus.BUSY), 32'd0);
    chk("rst Y", bus.Y, 32'd0);
    chk("rst Y_LAST", 32'(bus.Y_LAST), 32'd0);
    chk("rst Y_CH", 32'(bus.Y_CH), 32'd0);
    chk("rst BEAT_CNT", 32'(bus.BEAT_CNT), 32'd0);
    chk("rst D_READY", 32'(bus.D_READY), 32'd0);

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Test 3: sink stalls three cycles mid-frame.
    do_reset();
    drive(1'b0, 1'b0, 3'd2, 4'b0100, 4'b0000, 8'h60, 1'b1);
    #1; chk("stall rdy0", 32'(bus.D_READY), 32'b0100);
    @(posedge clk); #1;
    chk("stall Y0", bus.Y, 32'h6002BEEF);
    chk("stall cnt0", 32'(bus.BEAT_CNT), 32'(exp_cnt(0)));
    drive(1'b0, 1'b0, 3'd2, 4'b0100, 4'b0000, 8'h61, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("stall%0d rdy", k), 32'(bus.D_READY), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d Y", k), bus.Y, 32'h6002BEEF);
      chk($sformatf("stall%0d vld", k), 32'(bus.Y_VALID), 32'd1);
      chk($sformatf("stall%0d ch", k), 32'(bus.Y_CH), 32'd2);
      chk($sformatf("stall%0d cnt", k), 32'(bus.BEAT_CNT), 32'(exp_cnt(0)));
    end
    bus.Y_READY = 1'b1;
    #1; chk("resume rdy", 32'(bus.D_READY), 32'b0100);
    @(posedge clk); #1;
    chk("resume Y", bus.Y, 32'h6102BEEF);
    chk("resume cnt", 32'(bus.BEAT_CNT), 32'(exp_cnt(1)));
    drive(1'b0, 1'b0, 3'd2, 4'b0100, 4'b0100, 8'h62, 1'b1);
    @(posedge clk); #1;
    chk("last Y", bus.Y, 32'h6202BEEF);
    chk("last Y_LAST", 32'(bus.Y_LAST), 32'd1);
    chk("last BUSY", 32'(bus.BUSY), 32'd0);
    chk("last cnt", 32'(bus.BEAT_CNT), 32'(exp_cnt(2)));
    drive(1'b0, 1'b0, 3'd2, 4'b0000, 4'b0000, 8'h63, 1'b1);
    @(posedge clk); #1;
    chk("drain vld", 32'(bus.Y_VALID), 32'd0);
    chk("drain cnt", 32'(bus.BEAT_CNT), 32'(exp_cnt(3)));

    // Test 6: beat counter wrap (or stays zero when not built).
    do_reset();
    drive(1'b0, 1'b0, 3'd0, 4'b0001, 4'b0001, 8'h70, 1'b1);
    if (CNT_EN) begin
      repeat (65536) @(posedge clk);
      #1; chk("cnt ffff", 32'(bus.BEAT_CNT), 32'h0000FFFF);
      @(posedge clk); #1;
      chk("cnt wrap", 32'(bus.BEAT_CNT), 32'd0);
      bus.D_VALID = 4'b0000;
      @(posedge clk); #1;
      chk("cnt 65537", 32'(bus.BEAT_CNT), 32'd1);
    end else begin
      repeat (20) @(posedge clk);
      #1; chk("cnt off Y", bus.Y, 32'h7000BEEF);
      bus.D_VALID = 4'b0000;
      @(posedge clk); #1;
      chk("cnt off", 32'(bus.BEAT_CNT), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
